position_frame_serializer: RTL and testbench
============================================

// Module: position_frame_serializer
// PURPOSE
//  Downstream of each simulation core: on every completed Verlet step, snapshots the core's
//  NODE_COUNT node positions (x,y Q-format words) into a shadow bank.
//  Then streams them one node per beat over a valid/ready port toward the readout/display path.
//  The core never stalls; frames arriving while a previous frame is still streaming are dropped and counted.
// PARAMETERS
//  NODE_COUNT  5   nodes per core; must be >= 2
//  DATA_W      32  width of one coordinate word
//  CORE_ID     0   static tag copied onto every output beat
// PORTS
//  clk           in   1                  system clock; all logic on rising edge
//  reset         in   1                  asynchronous, active-low reset
//  step_done     in   1                  1-cycle pulse: node positions valid and stable this cycle
//  x_flat        in   NODE_COUNT*DATA_W  node i x at [i*DATA_W +: DATA_W]
//  y_flat        in   NODE_COUNT*DATA_W  node i y, same packing
//  out_valid     out  1                  beat available
//  out_ready     in   1                  consumer accepts the beat when out_valid & out_ready
//  out_core_id   out  8                  CORE_ID
//  out_frame     out  16                 frame number of the beat
//  out_node      out  clog2(NODE_COUNT)  node index of the beat
//  out_x         out  DATA_W             snapshot x of out_node
//  out_y         out  DATA_W             snapshot y of out_node
//  out_last      out  1                  high on the beat with out_node == NODE_COUNT-1
//  busy          out  1                  high while in SEND
//  overrun       out  1                  sticky; set on the first dropped frame
//  drop_count    out  16                 dropped frames; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, reset==0):
//   - state=IDLE; out_valid=0, out_node=0, out_frame=0, out_last=0, busy=0, overrun=0, drop_count=0
//   - out_x/out_y/shadow bank = 0
//   - out_valid drops in the same cycle reset asserts; an interrupted frame is discarded, never resumed.
//  Frame counter frame_ctr (16b, reset 0): increments on every captured frame; wraps FFFF->0000.
//  IDLE:
//   - step_done=1 -> capture x_flat/y_flat into the shadow bank at that edge
//   - out_frame<=frame_ctr, frame_ctr+=1, out_node<=0, go SEND
//   - out_valid=1 from the next cycle (capture-to-first-beat latency: 1 clk)
//  SEND:
//   - out_valid=1; out_x/out_y come from the shadow bank at out_node.
//   - Outputs hold stable while out_valid & !out_ready.
//   - Handshake with out_node < NODE_COUNT-1 -> out_node+=1.
//   - Handshake with out_node == NODE_COUNT-1 (out_last=1):
//       step_done=1 the same cycle -> capture the new frame, out_node<=0, stay SEND; no bubble, no drop
//       otherwise -> out_valid<=0, go IDLE
//  Drop: step_done=1 in SEND without the final handshake in that cycle.
//   - shadow bank untouched; frame_ctr still increments so gaps are visible downstream
//   - overrun<=1; drop_count += 1 unless already FFFF
//  out_valid never deasserts mid-frame without a handshake, except on reset.
//  x_flat/y_flat are sampled only on step_done; values outside that cycle are ignored.
// STRUCTURE
//  - Shared header sim_defs.vh: DATA_W default, FRAME_W=16, DROP_W=16, CORE_ID_W=8, state encodings
//    (ST_IDLE=1'b0, ST_SEND=1'b1).
//  - Sub-module frame_shadow_bank: NODE_COUNT x 2 x DATA_W register array with parallel load
//    (load, x_flat, y_flat) and an indexed read (idx -> rd_x, rd_y).
//    Reused later by the multi-core readout arbiter.
//  - The FSM, counters and handshake live in the top level.
// TESTING
//  1. Reset, step_done at cycle 10, x_i=i*0x100, y_i=i*0x10, out_ready=1 ->
//     beats on cycles 11..15, out_node 0..4, out_frame=0, out_last only on cycle 15, then out_valid=0.
//  2. Backpressure: out_ready low for 3 cycles on node 2 ->
//     out_node/out_x/out_y held constant for those 3 cycles; the frame completes with 5 beats total.
//  3. Overrun: second step_done while on node 1 ->
//     overrun=1, drop_count=1; current frame finishes with the original values;
//     the next captured frame carries out_frame=2.
//  4. Back-to-back: step_done in the same cycle as the out_last handshake ->
//     next cycle out_node=0, out_frame+1, out_valid stays 1; drop_count unchanged.
//  5. Reset asserted mid-frame (node 3, out_ready=0) ->
//     out_valid=0 combinationally; after release, IDLE with frame_ctr=0; the next frame is out_frame=0.
//  6. Saturation/wrap: preload via 65537 forced drops ->
//     drop_count sticks at FFFF; frame_ctr wraps to 0 without an X or glitch on out_frame.

Source files
------------

// File: rtl/position_frame_serializer_pkg.sv
// Shared widths, FSM encoding and a saturating counter helper for the
// position frame serializer and its shadow bank.
package position_frame_serializer_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int FRAME_W    = 16;
  localparam int DROP_W     = 16;
  localparam int CORE_ID_W  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_W-1:0] drop_sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/frame_shadow_bank.sv
// NODE_COUNT x (x,y) coordinate register bank: parallel load of a whole
// frame, indexed combinational read of one node.
module frame_shadow_bank
  import position_frame_serializer_pkg::*;
#(
  parameter  int NODE_COUNT = 5,
  parameter  int DATA_W     = DATA_W_DEF,
  localparam int IDX_W      = $clog2(NODE_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic [NODE_COUNT*DATA_W-1:0] x_flat,
  input  logic [NODE_COUNT*DATA_W-1:0] y_flat,
  input  logic [IDX_W-1:0]             idx,
  output logic [DATA_W-1:0]            rd_x,
  output logic [DATA_W-1:0]            rd_y
);

  logic [DATA_W-1:0] x_q [NODE_COUNT];
  logic [DATA_W-1:0] y_q [NODE_COUNT];

  // Snapshot every node of the incoming frame in one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NODE_COUNT; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < NODE_COUNT; i++) begin
        x_q[i] <= x_flat[i*DATA_W +: DATA_W];
        y_q[i] <= y_flat[i*DATA_W +: DATA_W];
      end
    end
  end

  assign rd_x = x_q[idx];
  assign rd_y = y_q[idx];

endmodule

// File: rtl/position_frame_serializer.sv
// Captures a core's node positions on each completed step and streams them
// one node per valid/ready beat. The core is never stalled: a frame that
// arrives while another is still streaming is dropped and counted.
module position_frame_serializer
  import position_frame_serializer_pkg::*;
#(
  parameter  int NODE_COUNT = 5,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int CORE_ID    = 0,
  localparam int NODE_W     = $clog2(NODE_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         step_done,
  input  logic [NODE_COUNT*DATA_W-1:0] x_flat,
  input  logic [NODE_COUNT*DATA_W-1:0] y_flat,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CORE_ID_W-1:0]         out_core_id,
  output logic [FRAME_W-1:0]           out_frame,
  output logic [NODE_W-1:0]            out_node,
  output logic [DATA_W-1:0]            out_x,
  output logic [DATA_W-1:0]            out_y,
  output logic                         out_last,
  output logic                         busy,
  output logic                         overrun,
  output logic [DROP_W-1:0]            drop_count
);

  localparam logic [NODE_W-1:0] LAST_NODE = NODE_W'(NODE_COUNT - 1);
  localparam logic [NODE_W-1:0] PENULT    = NODE_W'(NODE_COUNT - 2);

  state_e              state_q;
  logic                valid_q;
  logic                last_q;
  logic                overrun_q;
  logic [NODE_W-1:0]   node_q;
  logic [FRAME_W-1:0]  frame_q;
  logic [FRAME_W-1:0]  frame_ctr_q;
  logic [DROP_W-1:0]   drop_q;

  logic                hs;
  logic                final_hs;
  logic                load;
  logic                drop;

  // Handshake decode: a capture is allowed when idle or when the last beat
  // leaves this very cycle; any other step_done while sending is a drop.
  always_comb begin
    hs       = valid_q & out_ready;
    final_hs = hs & (node_q == LAST_NODE);
    load     = step_done & ((state_q == ST_IDLE) | final_hs);
    drop     = step_done & (state_q == ST_SEND) & ~final_hs;
  end

  frame_shadow_bank #(
    .NODE_COUNT (NODE_COUNT),
    .DATA_W     (DATA_W)
  ) u_bank (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .x_flat (x_flat),
    .y_flat (y_flat),
    .idx    (node_q),
    .rd_x   (out_x),
    .rd_y   (out_y)
  );

  // Streaming FSM with frame numbering and drop accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      overrun_q   <= 1'b0;
      node_q      <= '0;
      frame_q     <= '0;
      frame_ctr_q <= '0;
      drop_q      <= '0;
    end else begin
      if (load) begin
        frame_q <= frame_ctr_q;
        node_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b1;
        state_q <= ST_SEND;
      end else if (hs) begin
        if (node_q == LAST_NODE) begin
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          state_q <= ST_IDLE;
        end else begin
          node_q <= node_q + NODE_W'(1);
          last_q <= (node_q == PENULT);
        end
      end
      // Dropped frames still consume a number so gaps show downstream.
      if (step_done) begin
        frame_ctr_q <= frame_ctr_q + FRAME_W'(1);
      end
      if (drop) begin
        overrun_q <= 1'b1;
        drop_q    <= drop_sat_inc(drop_q);
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_core_id = CORE_ID_W'(CORE_ID);
  assign out_frame   = frame_q;
  assign out_node    = node_q;
  assign out_last    = last_q;
  assign busy        = (state_q == ST_SEND);
  assign overrun     = overrun_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_position_frame_serializer.sv
// Bench for position_frame_serializer: directed scenarios plus randomized
// traffic, checked against a queue-of-pending-beats reference model.
module tb_position_frame_serializer;

  localparam int NC  = 5;
  localparam int DW  = 32;
  localparam int CID = 3;
  localparam int NW  = $clog2(NC);

  logic             clk = 1'b0;
  logic             reset;
  logic             step_done;
  logic [NC*DW-1:0] x_flat;
  logic [NC*DW-1:0] y_flat;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_core_id;
  logic [15:0]      out_frame;
  logic [NW-1:0]    out_node;
  logic [DW-1:0]    out_x;
  logic [DW-1:0]    out_y;
  logic             out_last;
  logic             busy;
  logic             overrun;
  logic [15:0]      drop_count;

  position_frame_serializer #(.NODE_COUNT(NC), .DATA_W(DW), .CORE_ID(CID)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_done   (step_done),
    .x_flat      (x_flat),
    .y_flat      (y_flat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_core_id (out_core_id),
    .out_frame   (out_frame),
    .out_node    (out_node),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_last    (out_last),
    .busy        (busy),
    .overrun     (overrun),
    .drop_count  (drop_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the beats still owed to the consumer, in order.
  typedef struct {
    logic [15:0]   f;
    logic [NW-1:0] n;
    logic [DW-1:0] x;
    logic [DW-1:0] y;
  } beat_t;

  beat_t       mq[$];
  logic [15:0] m_ctr;
  logic [15:0] m_drops;
  bit          m_ovr;

  task automatic model_reset();
    mq.delete();
    m_ctr   = 16'd0;
    m_drops = 16'd0;
    m_ovr   = 1'b0;
  endtask

  task automatic rand_data();
    for (int i = 0; i < NC; i++) begin
      x_flat[i*DW +: DW] = $urandom;
      y_flat[i*DW +: DW] = $urandom;
    end
  endtask

  // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
  task automatic tick(input bit sd, input bit rdy);
    beat_t b;
    step_done = sd;
    out_ready = rdy;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (sd) begin
      if (mq.size() == 0) begin
        for (int i = 0; i < NC; i++) begin
          b.f = m_ctr;
          b.n = NW'(i);
          b.x = x_flat[i*DW +: DW];
          b.y = y_flat[i*DW +: DW];
          mq.push_back(b);
        end
      end else begin
        m_ovr = 1'b1;
        if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
      end
      m_ctr = m_ctr + 16'd1;
    end
    @(posedge clk);
    #1;
    step_done = 1'b0;
  endtask

  task automatic apply_reset();
    reset     = 1'b0;
    step_done = 1'b0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if (out_valid !== 1'b0 || out_node !== '0 || out_frame !== 16'd0 || out_last !== 1'b0 ||
        busy !== 1'b0 || overrun !== 1'b0 || drop_count !== 16'd0 || out_x !== '0 || out_y !== '0) begin
      n_err++;
      $display("FAIL reset_state got v=%b n=%0d f=%0d l=%b b=%b o=%b d=%0d x=%h y=%h want all zero",
               out_valid, out_node, out_frame, out_last, busy, overrun, drop_count, out_x, out_y);
    end
    n_cmp++;
    if (out_core_id !== 8'(CID)) begin
      n_err++;
      $display("FAIL core_id got %0d want %0d", out_core_id, CID);
    end
  endtask

  task automatic test_basic_frame();
    for (int i = 0; i < NC; i++) begin
      x_flat[i*DW +: DW] = DW'(i * 32'h100);
      y_flat[i*DW +: DW] = DW'(i * 32'h10);
    end
    repeat (9) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    for (int k = 0; k <= NC; k++) begin
      n_cmp++;
      if (k < NC) begin
        if (out_valid !== 1'b1 || out_node !== NW'(k) || out_frame !== 16'd0 ||
            out_x !== DW'(k * 32'h100) || out_y !== DW'(k * 32'h10) || out_last !== (k == NC - 1)) begin
          n_err++;
          $display("FAIL basic_beat%0d got v=%b n=%0d f=%0d x=%h y=%h l=%b want v=1 n=%0d f=0 x=%h y=%h l=%b",
                   k, out_valid, out_node, out_frame, out_x, out_y, out_last,
                   k, k * 32'h100, k * 32'h10, (k == NC - 1));
        end
      end else if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL basic_end got v=%b busy=%b want v=0 busy=0", out_valid, busy);
      end
      tick(1'b0, 1'b1);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] hx;
    logic [DW-1:0] hy;
    int beats;
    rand_data();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    hx = mq[0].x;
    hy = mq[0].y;
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0);
      n_cmp++;
      if (out_valid !== 1'b1 || out_node !== NW'(2) || out_x !== hx || out_y !== hy) begin
        n_err++;
        $display("FAIL bp_hold%0d got v=%b n=%0d x=%h y=%h want v=1 n=2 x=%h y=%h",
                 k, out_valid, out_node, out_x, out_y, hx, hy);
      end
    end
    beats = 2;
    for (int k = 0; k < 8; k++) begin
      if (out_valid === 1'b1) beats++;
      tick(1'b0, 1'b1);
    end
    n_cmp++;
    if (beats != NC) begin
      n_err++;
      $display("FAIL bp_beats got %0d want %0d", beats, NC);
    end
  endtask

  task automatic test_overrun();
    apply_reset();
    rand_data();
    tick(1'b1, 1'b1);
    tick(1'b0, 1'b1);
    rand_data();
    tick(1'b1, 1'b0);
    n_cmp++;
    if (overrun !== 1'b1 || drop_count !== 16'd1 || out_node !== NW'(1)) begin
      n_err++;
      $display("FAIL ovr_flags got o=%b d=%0d n=%0d want o=1 d=1 n=1", overrun, drop_count, out_node);
    end
    for (int k = 1; k <= NC; k++) begin
      n_cmp++;
      if (out_valid !== (mq.size() > 0)) begin
        n_err++;
        $display("FAIL ovr_valid%0d got %b want %b", k, out_valid, (mq.size() > 0));
      end else if (mq.size() > 0 && (out_node !== mq[0].n || out_frame !== mq[0].f ||
                                     out_x !== mq[0].x || out_y !== mq[0].y)) begin
        n_err++;
        $display("FAIL ovr_beat%0d got n=%0d f=%0d x=%h y=%h want n=%0d f=%0d x=%h y=%h",
                 k, out_node, out_frame, out_x, out_y, mq[0].n, mq[0].f, mq[0].x, mq[0].y);
      end
      tick(1'b0, 1'b1);
    end
    rand_data();
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_frame !== 16'd2) begin
      n_err++;
      $display("FAIL ovr_next_frame got v=%b f=%0d want v=1 f=2", out_valid, out_frame);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pf;
    logic [15:0] pd;
    repeat (NC + 1) tick(1'b0, 1'b1);
    rand_data();
    tick(1'b1, 1'b1);
    repeat (NC - 1) tick(1'b0, 1'b1);
    n_cmp++;
    if (out_last !== 1'b1 || out_node !== NW'(NC - 1)) begin
      n_err++;
      $display("FAIL b2b_last got l=%b n=%0d want l=1 n=%0d", out_last, out_node, NC - 1);
    end
    pf = mq[0].f;
    pd = m_drops;
    rand_data();
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_node !== '0 || out_frame !== pf + 16'd1 ||
        drop_count !== pd || out_x !== x_flat[DW-1:0]) begin
      n_err++;
      $display("FAIL b2b_next got v=%b n=%0d f=%0d d=%0d x=%h want v=1 n=0 f=%0d d=%0d x=%h",
               out_valid, out_node, out_frame, drop_count, out_x, pf + 16'd1, pd, x_flat[DW-1:0]);
    end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    rand_data();
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    n_cmp++;
    if (out_valid !== 1'b1 || out_node !== NW'(3)) begin
      n_err++;
      $display("FAIL rmid_pre got v=%b n=%0d want v=1 n=3", out_valid, out_node);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_node !== '0) begin
      n_err++;
      $display("FAIL rmid_async got v=%b busy=%b n=%0d want v=0 busy=0 n=0", out_valid, busy, out_node);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick(1'b0, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_idle got v=%b want 0", out_valid);
    end
    rand_data();
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_frame !== 16'd0 || out_y !== mq[0].y) begin
      n_err++;
      $display("FAIL rmid_next got v=%b f=%0d y=%h want v=1 f=0 y=%h", out_valid, out_frame, out_y, mq[0].y);
    end
  endtask

  task automatic test_random();
    bit sd;
    bit rdy;
    for (int c = 0; c < 400; c++) begin
      rand_data();
      sd  = ($urandom_range(0, 5) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tick(sd, rdy);
      n_cmp++;
      if (out_valid !== (mq.size() > 0) || busy !== (mq.size() > 0) ||
          overrun !== m_ovr || drop_count !== m_drops) begin
        n_err++;
        $display("FAIL rnd_ctrl c=%0d got v=%b b=%b o=%b d=%0d want v=%b o=%b d=%0d",
                 c, out_valid, busy, overrun, drop_count, (mq.size() > 0), m_ovr, m_drops);
      end else if (mq.size() > 0 && (out_node !== mq[0].n || out_frame !== mq[0].f || out_x !== mq[0].x ||
                                     out_y !== mq[0].y || out_last !== (mq[0].n == NW'(NC - 1)))) begin
        n_err++;
        $display("FAIL rnd_beat c=%0d got n=%0d f=%0d x=%h y=%h l=%b want n=%0d f=%0d x=%h y=%h",
                 c, out_node, out_frame, out_x, out_y, out_last, mq[0].n, mq[0].f, mq[0].x, mq[0].y);
      end
    end
  endtask

  task automatic test_saturation();
    int bad;
    apply_reset();
    rand_data();
    tick(1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 65537; k++) begin
      tick(1'b1, 1'b0);
      if ($isunknown(out_frame) || out_frame !== 16'd0 || out_valid !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL sat_hold got %0d bad cycles want 0", bad);
    end
    n_cmp++;
    if (drop_count !== 16'hFFFF || drop_count !== m_drops || overrun !== 1'b1) begin
      n_err++;
      $display("FAIL sat_drops got d=%h o=%b want d=ffff o=1", drop_count, overrun);
    end
    repeat (NC + 1) tick(1'b0, 1'b1);
    rand_data();
    tick(1'b1, 1'b1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_frame !== 16'd2 || out_frame !== mq[0].f || drop_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL sat_wrap got v=%b f=%0d d=%h want v=1 f=2 d=ffff", out_valid, out_frame, drop_count);
    end
  endtask

  initial begin
    reset     = 1'b0;
    step_done = 1'b0;
    out_ready = 1'b0;
    x_flat    = '0;
    y_flat    = '0;
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
